// File: rtl/maint_arbiter.sv
// ============================================================================
// Module      : maint_arbiter
// Description : Arbitrates the DDR command path between the instruction
//               program and the maintenance controller, tracking refresh debt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maint_arbiter #(
  parameter int FORCE_THRESH = 4,
  parameter int MAX_DEBT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_calib_complete,
  input  logic       prog_req,
  input  logic       prog_fin,
  input  logic       maint_req,
  input  logic       maint_fin,
  input  logic       ref_tick,
  input  logic       ref_done,
  output logic       program_process,
  output logic       maint_ack,
  output logic       maint_busy,
  output logic [3:0] ref_debt,
  output logic       debt_overflow
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PROG  = 2'd1;
  localparam logic [1:0] c_MACK  = 2'd2;
  localparam logic [1:0] c_MAINT = 2'd3;

  localparam logic [31:0] c_FORCE_THRESH = FORCE_THRESH;
  localparam logic [31:0] c_MAX_DEBT     = MAX_DEBT;

  logic [1:0] state_q, state_d;
  logic       last_prog_q, last_prog_d;
  logic       calib_q;
  logic       prog_q, prog_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic [3:0] debt_q, debt_d;
  logic       ovf_q, ovf_d;
  logic       w_force;

  assign w_force = ({28'd0, debt_q} >= c_FORCE_THRESH);

  // Calibration is registered once; this also delays the first grant after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      last_prog_q <= 1'b0;
      calib_q     <= 1'b0;
      prog_q      <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_prog_q <= last_prog_d;
      calib_q     <= init_calib_complete;
      prog_q      <= prog_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_prog_d = last_prog_q;
    case (state_q)
      c_IDLE: begin
        if (calib_q) begin
          if (maint_req && (w_force || !prog_req || last_prog_q)) begin
            state_d     = c_MACK;
            last_prog_d = 1'b0;
          end else if (prog_req) begin
            state_d     = c_PROG;
            last_prog_d = 1'b1;
          end
        end
      end
      c_PROG:  if (prog_fin)  state_d = c_IDLE;
      c_MACK:  state_d = c_MAINT;
      c_MAINT: if (maint_fin) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_comb begin
    prog_d = (state_d == c_PROG);
    ack_d  = (state_d == c_MACK);
    busy_d = (state_d == c_MAINT);
  end

  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (ref_tick && !ref_done) begin
      if ({28'd0, debt_q} >= c_MAX_DEBT) ovf_d = 1'b1;
      if (debt_q != 4'd15) debt_d = debt_q + 4'd1;
    end else if (ref_done && !ref_tick && (debt_q != 4'd0)) begin
      debt_d = debt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      debt_q <= 4'd0;
      ovf_q  <= 1'b0;
    end else begin
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign program_process = prog_q;
  assign maint_ack       = ack_q;
  assign maint_busy      = busy_q;
  assign ref_debt        = debt_q;
  assign debt_overflow   = ovf_q;

endmodule

`default_nettype wire

// File: doc/maint_arbiter.md
MAINT_ARBITER -- requirements
Module: maint_arbiter

Interface
REQ-001 SHALL have parameter FORCE_THRESH, default 4: refresh-debt level at or above which maintenance wins arbitration over a program.
REQ-002 SHALL have parameter MAX_DEBT, default 8: refresh-debt level at which the overflow flag arms.
REQ-003 SHALL have port clk, input, 1: single clock for all logic; one clock only.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port init_calib_complete, input, 1: PHY calibration done; no grants while low.
REQ-006 SHALL have port prog_req, input, 1: level request from the host to run the instruction program.
REQ-007 SHALL have port prog_fin, input, 1: one-cycle pulse, program execution finished.
REQ-008 SHALL have port maint_req, input, 1: level request from the maintenance controller.
REQ-009 SHALL have port maint_fin, input, 1: one-cycle pulse, maintenance sequence finished.
REQ-010 SHALL have port ref_tick, input, 1: one-cycle pulse per tREFI interval elapsed.
REQ-011 SHALL have port ref_done, input, 1: one-cycle pulse, one maintenance refresh issued.
REQ-012 SHALL have port program_process, output, 1: program owns the command path.
REQ-013 SHALL have port maint_ack, output, 1: one-cycle grant pulse to the maintenance controller.
REQ-014 SHALL have port maint_busy, output, 1: maintenance owns the command path.
REQ-015 SHALL have port ref_debt, output, 4: count of outstanding refreshes.
REQ-016 SHALL have port debt_overflow, output, 1: sticky flag, refresh debt exceeded MAX_DEBT.

Function
REQ-017 SHALL implement FSM states IDLE, PROG, MACK, MAINT; all outputs registered.
REQ-018 IDLE with init_calib_complete low SHALL remain IDLE regardless of requests.
REQ-019 IDLE arbitration SHALL choose MACK if maint_req and (ref_debt >= FORCE_THRESH, or prog_req low, or last_owner == PROG).
REQ-020 IDLE arbitration SHALL otherwise choose PROG if prog_req is high.
REQ-021 last_owner SHALL be a 1-bit register updated on each grant; it SHALL reset to MAINT, so a program wins the first tie.
REQ-022 MACK SHALL last exactly one cycle with maint_ack=1, then go to MAINT.
REQ-023 MAINT SHALL hold maint_busy=1 until the cycle maint_fin=1, then return to IDLE with maint_busy=0 on the next cycle.
REQ-024 PROG SHALL hold program_process=1 until prog_fin=1, then return to IDLE; a program is never preempted.
REQ-025 program_process and maint_busy SHALL never both be 1.
REQ-026 Grant latency SHALL be one cycle from the qualifying IDLE cycle to state-output assertion.
REQ-027 At least one IDLE cycle SHALL separate any two ownership periods.
REQ-028 prog_fin outside PROG and maint_fin outside MAINT SHALL be ignored.
REQ-029 ref_debt SHALL update each cycle as follows:
- +1 on ref_tick alone, saturating at 15;
- -1 on ref_done alone, floored at 0;
- unchanged when both pulse together.
REQ-030 debt_overflow SHALL set when ref_tick arrives alone with ref_debt >= MAX_DEBT, and stay set until reset.
REQ-031 ref_tick and ref_done SHALL be counted in every state, including while init_calib_complete is low.
REQ-032 init_calib_complete falling mid-ownership SHALL NOT abort PROG or MAINT; it only blocks new grants from IDLE.

Reset
REQ-033 rst=1 SHALL force, on the next edge, from any state including mid-PROG or mid-MAINT:
- state=IDLE, last_owner=MAINT;
- program_process=0, maint_ack=0, maint_busy=0;
- ref_debt=0, debt_overflow=0.
REQ-034 The first grant after rst deasserts SHALL occur no earlier than the second cycle after deassertion.

Verification
REQ-035 Calibration gating: init_calib_complete=0, prog_req=1, maint_req=1 for 20 cycles -> no grant; raise calib -> program_process=1 two cycles later (last_owner reset to MAINT).
REQ-036 Tie alternation: prog_req and maint_req held high, ref_debt=0, fins pulsed 3 cycles after each grant -> grants alternate PROG, MAINT, PROG, MAINT; maint_ack pulses exactly once per MAINT entry.
REQ-037 Forced maintenance: 4 ref_ticks, then PROG completes with both requests high -> MAINT granted; with ref_debt=3 and last_owner=MAINT -> PROG granted.
REQ-038 Debt arithmetic: 16 ref_ticks -> ref_debt=15, debt_overflow=1; simultaneous tick+done -> debt unchanged; ref_done at 0 -> remains 0.
REQ-039 Reset mid-MAINT: rst pulsed during MAINT with ref_debt=5 -> next cycle maint_busy=0, ref_debt=0, state IDLE; a maint_fin pulse afterward is ignored.
REQ-040 Stray finishes: prog_fin pulsed in IDLE and MAINT -> no state change; maint_fin pulsed in PROG -> program_process stays 1.
